conv_arbiter: RTL and testbench

Round-robin arbiter that shares the single MAC/accumulator datapath and output y-stream between NUM_CT convolution control units. Each unit requests the datapath once its x/f memories are loaded. It holds the grant until its conv_done pulse, then releases it. The arbiter drives each unit's `other_ct_in_comp` input, steers the output handshake to the owner, and flags protocol errors and overlong grants.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/rr_pick_onehot.sv | 20 ++
 rtl/conv_arbiter.sv | 103 ++++++++++
 tb/tb_conv_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution datapath arbiter.
package conv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_GAP  = 2'b10
    } arb_state_t;

    localparam int MAX_CT = 8;

    // Zero-padded requests above NUM_CT are never picked, so the mod-8 walk is equivalent to mod NUM_CT.
    function automatic logic [MAX_CT-1:0] rr_pick(input logic [MAX_CT-1:0] req,
                                                  input logic [2:0]        last);
        logic [MAX_CT-1:0] pick;
        logic              found;
        logic [2:0]        idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_CT; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Round-robin one-hot pick: rotate so index last+1 sits at bit 0, take the lowest set bit, rotate back.
module rr_pick_onehot #(
    parameter int NUM_CT    = 2,
    parameter int LG_NUM_CT = 1
) (
    input  logic [NUM_CT-1:0]    req,
    input  logic [LG_NUM_CT-1:0] last,
    output logic [NUM_CT-1:0]    pick
);

    logic [LG_NUM_CT:0] sh;
    logic [NUM_CT-1:0]  rot;
    logic [NUM_CT-1:0]  rot_pick;

    assign sh       = {1'b0, last} + (LG_NUM_CT+1)'(1);
    assign rot      = NUM_CT'({req, req} >> sh);
    assign rot_pick = rot & (~rot + NUM_CT'(1));
    assign pick     = NUM_CT'({rot_pick, rot_pick} >> (NUM_CT - int'(sh)));

endmodule

// File: rtl/conv_arbiter.sv
// Round-robin owner of the shared MAC/accumulator datapath and y-stream among NUM_CT control units.
module conv_arbiter
    import conv_pkg::*;
#(
    parameter int NUM_CT     = 2,
    parameter int LG_NUM_CT  = 1,
    parameter int TIMEOUT    = 1024,
    parameter int LG_TIMEOUT = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CT-1:0]    req,
    input  logic [NUM_CT-1:0]    done,
    output logic [NUM_CT-1:0]    hold_off,
    output logic [NUM_CT-1:0]    gnt,
    output logic [LG_NUM_CT-1:0] sel,
    output logic                 busy,
    input  logic [NUM_CT-1:0]    ct_m_valid_y,
    output logic [NUM_CT-1:0]    ct_m_ready_y,
    output logic                 m_valid_y,
    input  logic                 m_ready_y,
    output logic                 err_proto,
    output logic                 err_timeout
);

    localparam logic [LG_TIMEOUT-1:0] TIMEOUT_CNT = LG_TIMEOUT'(TIMEOUT);

    arb_state_t             state, state_next;
    logic [NUM_CT-1:0]      pick;
    logic [LG_NUM_CT-1:0]   pick_idx;
    logic [LG_NUM_CT-1:0]   last;
    logic [LG_TIMEOUT-1:0]  cnt;
    logic                   owner_done;
    logic                   owner_drop;

    rr_pick_onehot #(
        .NUM_CT    (NUM_CT),
        .LG_NUM_CT (LG_NUM_CT)
    ) u_pick (
        .req  (req),
        .last (last),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_CT; i++) begin
            if (pick[i]) pick_idx = LG_NUM_CT'(i);
        end
    end

    assign owner_done = |(done & gnt);
    assign owner_drop = ~|(req & gnt);

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (|req) state_next = ARB_BUSY;
            ARB_BUSY: if (owner_done || owner_drop) state_next = ARB_GAP;
            ARB_GAP:  state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            sel         <= '0;
            last        <= LG_NUM_CT'(NUM_CT - 1);
            busy        <= 1'b0;
            cnt         <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ARB_BUSY);
            // gnt is zero outside BUSY, so this also catches any done while not granted
            if (|(done & ~gnt)) err_proto <= 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        gnt  <= pick;
                        sel  <= pick_idx;
                        last <= pick_idx;
                        cnt  <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (state_next == ARB_GAP) gnt <= '0;
                    if (cnt != '1) cnt <= cnt + LG_TIMEOUT'(1);
                    if (cnt >= TIMEOUT_CNT) err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hold_off     = ~gnt;
    assign m_valid_y    = busy & ct_m_valid_y[sel];
    assign ct_m_ready_y = gnt & {NUM_CT{m_ready_y}};

endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter with two units and a short timeout.
module tb_conv_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] done = '0;
    logic [1:0] hold_off;
    logic [1:0] gnt;
    logic [0:0] sel;
    logic       busy;
    logic [1:0] ct_m_valid_y = '0;
    logic [1:0] ct_m_ready_y;
    logic       m_valid_y;
    logic       m_ready_y = 1'b0;
    logic       err_proto;
    logic       err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_arbiter #(
        .NUM_CT     (2),
        .LG_NUM_CT  (1),
        .TIMEOUT    (8),
        .LG_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .done         (done),
        .hold_off     (hold_off),
        .gnt          (gnt),
        .sel          (sel),
        .busy         (busy),
        .ct_m_valid_y (ct_m_valid_y),
        .ct_m_ready_y (ct_m_ready_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y),
        .err_proto    (err_proto),
        .err_timeout  (err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        done = '0;
        ct_m_valid_y = '0;
        m_ready_y = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ct_m_valid_y = 2'b11;
        m_ready_y = 1'b1;
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        total++; if (hold_off !== 2'b11) begin bad++; $display("FAIL reset_hold_off: got %b want 11", hold_off); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b want 0", sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({err_proto, err_timeout} !== 2'b00) begin bad++; $display("FAIL reset_errs: got %b want 00", {err_proto, err_timeout}); end
        total++; if (m_valid_y !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid_y); end
        total++; if (ct_m_ready_y !== 2'b00) begin bad++; $display("FAIL reset_ct_ready: got %b want 00", ct_m_ready_y); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        req = 2'b01;
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
        total++; if (hold_off !== 2'b10) begin bad++; $display("FAIL single_hold_off: got %b want 10", hold_off); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_hold: got %b want 01", gnt); end
        done = 2'b01;
        tick();
        done = 2'b00;
        req = 2'b00;
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_release: got %b want 00", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_off: got %b want 0", busy); end
        total++; if (hold_off !== 2'b11) begin bad++; $display("FAIL single_hold_off_rel: got %b want 11", hold_off); end
        tick();
        tick();
        total++; if (err_proto !== 1'b0) begin bad++; $display("FAIL single_err_proto: got %b want 0", err_proto); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req = 2'b11;
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL simul_first: got %b want 01", gnt); end
        done = 2'b01;
        tick();
        done = 2'b00;
        req = 2'b10;
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL simul_edge1: got %b want 00", gnt); end
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL simul_edge2: got %b want 00", gnt); end
        tick();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL simul_edge3: got %b want 10", gnt); end
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL simul_sel: got %b want 1", sel); end
        req = 2'b00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_gnt;
        bit         got;
        apply_reset();
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                if (gnt !== 2'b00) got = 1'b1;
                else tick();
            end
            total++;
            if (!got) begin
                bad++; $display("FAIL fair_wait_%0d: got %b want %b (no grant in 10 cycles)", i, gnt, exp_gnt);
            end else if (gnt !== exp_gnt) begin
                bad++; $display("FAIL fair_order_%0d: got %b want %b", i, gnt, exp_gnt);
            end
            done = gnt;
            tick();
            done = 2'b00;
        end
        req = 2'b00;
        tick();
        tick();
        total++; if (err_proto !== 1'b0) begin bad++; $display("FAIL fair_err_proto: got %b want 0", err_proto); end
    endtask

    task automatic test_steering();
        apply_reset();
        req = 2'b10;
        tick();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL steer_gnt: got %b want 10", gnt); end
        ct_m_valid_y = 2'b11;
        m_ready_y = 1'b1;
        #1;
        total++; if (m_valid_y !== 1'b1) begin bad++; $display("FAIL steer_valid: got %b want 1", m_valid_y); end
        total++; if (ct_m_ready_y !== 2'b10) begin bad++; $display("FAIL steer_ready: got %b want 10", ct_m_ready_y); end
        ct_m_valid_y = 2'b01;
        #1;
        total++; if (m_valid_y !== 1'b0) begin bad++; $display("FAIL steer_nonowner_valid: got %b want 0", m_valid_y); end
        m_ready_y = 1'b0;
        #1;
        total++; if (ct_m_ready_y !== 2'b00) begin bad++; $display("FAIL steer_no_ready: got %b want 00", ct_m_ready_y); end
        ct_m_valid_y = 2'b00;
        done = 2'b10;
        tick();
        done = 2'b00;
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_spurious_abort();
        apply_reset();
        req = 2'b01;
        tick();
        done = 2'b10;
        tick();
        done = 2'b00;
        total++; if (err_proto !== 1'b1) begin bad++; $display("FAIL spur_err: got %b want 1", err_proto); end
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL spur_keep: got %b want 01", gnt); end
        req = 2'b00;
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL abort_release: got %b want 00", gnt); end
        tick();
        tick();
        total++; if (err_proto !== 1'b1) begin bad++; $display("FAIL spur_sticky: got %b want 1", err_proto); end
    endtask

    task automatic test_timeout_reset();
        apply_reset();
        total++; if (err_proto !== 1'b0) begin bad++; $display("FAIL to_proto_clr: got %b want 0", err_proto); end
        req = 2'b01;
        tick();
        repeat (5) tick();
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", err_timeout); end
        repeat (5) tick();
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", err_timeout); end
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL to_still_held: got %b want 01", gnt); end
        done = 2'b10;
        tick();
        done = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_mid_gnt: got %b want 00", gnt); end
        total++; if ({err_proto, err_timeout} !== 2'b00) begin bad++; $display("FAIL rst_mid_errs: got %b want 00", {err_proto, err_timeout}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        #1;
        reset = 1'b0;
        req = 2'b11;
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rst_priority: got %b want 01", gnt); end
        req = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_steering();
        test_spurious_abort();
        test_timeout_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
